// File: rtl/dram_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dram_pkg
// Purpose  : Shared widths, state encoding and helpers for the DRAM packer.
// Revision : 1.0 - initial release
// ============================================================================
package dram_pkg;

    localparam int c_def_in_w   = 8;
    localparam int c_def_out_w  = 163;
    localparam int c_def_addr_w = 8;
    localparam int c_def_depth  = 256;

    typedef enum logic [0:0] {
        FILL  = 1'b0,
        FLUSH = 1'b1
    } pack_state_t;

    // Bits needed to count 0..out_w held bits.
    function automatic int fill_width(input int out_w);
        return $clog2(out_w + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/dram_packer_addr_gen.sv
`default_nettype none
// ============================================================================
// Module   : dram_packer_addr_gen
// Purpose  : Wrapping BRAM write-address counter with end-of-buffer pulse.
// Revision : 1.0 - initial release
// ============================================================================
module dram_packer_addr_gen #(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              advance,
    output logic [ADDR_W-1:0] addr,
    output logic              buf_done
);

    localparam logic [ADDR_W-1:0] c_last = ADDR_W'(DEPTH - 1);

    logic [ADDR_W-1:0] r_addr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_addr <= '0;
        end else if (clear) begin
            r_addr <= '0;
        end else if (advance) begin
            r_addr <= (r_addr == c_last) ? '0 : r_addr + ADDR_W'(1);
        end
    end

    assign addr     = r_addr;
    assign buf_done = advance && (r_addr == c_last);

endmodule
`default_nettype wire

// File: rtl/dram_stream_packer.sv
`default_nettype none
// ============================================================================
// Module   : dram_stream_packer
// Purpose  : Packs IN_W-bit DRAM beats MSB-first into OUT_W-bit BRAM words.
//            Optional output backpressure: DRAM_PACKER_BACKPRESSURE_EN.
// Revision : 1.0 - initial release
// ============================================================================
module dram_stream_packer
    import dram_pkg::*;
#(
    parameter int IN_W   = c_def_in_w,
    parameter int OUT_W  = c_def_out_w,
    parameter int ADDR_W = c_def_addr_w,
    parameter int DEPTH  = c_def_depth
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    input  logic [IN_W-1:0]            in_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       flush,
`ifdef DRAM_PACKER_BACKPRESSURE_EN
    input  logic                       bram_ready,
`endif
    output logic [OUT_W-1:0]           bram_data,
    output logic                       bram_write_enable,
    output logic [ADDR_W-1:0]          bram_addr,
    output logic                       buf_done,
    output logic [$clog2(OUT_W+1)-1:0] fill_level
);

    localparam int c_fill_w = fill_width(OUT_W);
    localparam int c_sum_w  = $clog2(OUT_W + IN_W + 1);
    localparam int c_acc_w  = OUT_W + IN_W - 1;

    pack_state_t         r_state;
    pack_state_t         w_state_next;
    logic [c_acc_w-1:0]  r_acc;
    logic [c_fill_w-1:0] r_fill;
    logic [OUT_W-1:0]    r_data;
    logic                r_we;

    logic                w_out_free;
    logic                w_wr_done;
    logic                w_accept;
    logic [c_sum_w-1:0]  w_sum;
    logic [c_sum_w-1:0]  w_shift;
    logic                w_complete;
    logic [c_acc_w-1:0]  w_ext;
    logic [c_acc_w-1:0]  w_rem;

`ifdef DRAM_PACKER_BACKPRESSURE_EN
    assign w_out_free = !r_we || bram_ready;
    assign w_wr_done  = r_we && bram_ready;
`else
    assign w_out_free = 1'b1;
    assign w_wr_done  = r_we;
`endif

    // The accumulator is kept MSB-aligned; a beat lands just below the held bits.
    assign w_accept   = in_valid && in_ready && !clear;
    assign w_sum      = c_sum_w'(r_fill) + c_sum_w'(IN_W);
    assign w_complete = w_sum >= c_sum_w'(OUT_W);
    assign w_shift    = c_sum_w'(OUT_W - 1) - c_sum_w'(r_fill);
    assign w_ext      = r_acc | (c_acc_w'(in_data) << w_shift);
    assign w_rem      = w_ext << OUT_W;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= FILL;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        case (r_state)
            FILL: begin
                in_ready = w_out_free;
                if (flush) begin
                    w_state_next = FLUSH;
                end
            end
            FLUSH: begin
                if (w_out_free || r_fill == '0) begin
                    w_state_next = FILL;
                end
            end
            default: w_state_next = FILL;
        endcase
        if (clear) begin
            w_state_next = FILL;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_acc  <= '0;
            r_fill <= '0;
            r_data <= '0;
            r_we   <= 1'b0;
        end else if (clear) begin
            r_acc  <= '0;
            r_fill <= '0;
            r_we   <= 1'b0;
        end else begin
            if (w_wr_done) begin
                r_we <= 1'b0;
            end
            if (w_accept) begin
                if (w_complete) begin
                    r_data <= w_ext[c_acc_w-1 -: OUT_W];
                    r_we   <= 1'b1;
                    r_acc  <= w_rem;
                    r_fill <= c_fill_w'(w_sum - c_sum_w'(OUT_W));
                end else begin
                    r_acc  <= w_ext;
                    r_fill <= c_fill_w'(w_sum);
                end
            end else if (r_state == FLUSH && r_fill != '0 && w_out_free) begin
                // Unfilled low bits are already zero in the accumulator.
                r_data <= r_acc[c_acc_w-1 -: OUT_W];
                r_we   <= 1'b1;
                r_acc  <= '0;
                r_fill <= '0;
            end
        end
    end

    dram_packer_addr_gen #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_addr_gen (
        .clk      (clk),
        .rst      (rst),
        .clear    (clear),
        .advance  (w_wr_done),
        .addr     (bram_addr),
        .buf_done (buf_done)
    );

    assign bram_data         = r_data;
    assign bram_write_enable = r_we;
    assign fill_level        = r_fill;

endmodule
`default_nettype wire

// File: tb/tb_dram_stream_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_dram_stream_packer
// Purpose  : Directed self-checking bench for dram_stream_packer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dram_stream_packer;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         clear = 1'b0;
    logic [7:0]   in_data = 8'h00;
    logic         in_valid = 1'b0;
    logic         flush = 1'b0;
    logic         in_ready;
    logic [162:0] bram_data;
    logic         bram_write_enable;
    logic [7:0]   bram_addr;
    logic         buf_done;
    logic [7:0]   fill_level;

    logic [7:0]   sm_in_data = 8'h00;
    logic         sm_in_valid = 1'b0;
    logic         sm_in_ready;
    logic [15:0]  sm_bram_data;
    logic         sm_bram_we;
    logic [1:0]   sm_bram_addr;
    logic         sm_buf_done;
    logic [4:0]   sm_fill_level;

    int checks = 0;
    int errors = 0;

    logic [162:0] wr_data_q[$];
    logic [7:0]   wr_addr_q[$];
    logic [15:0]  sm_data_q[$];
    logic [1:0]   sm_addr_q[$];
    logic         sm_done_q[$];

    dram_stream_packer dut (
        .clk               (clk),
        .rst               (rst),
        .clear             (clear),
        .in_data           (in_data),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .flush             (flush),
        .bram_data         (bram_data),
        .bram_write_enable (bram_write_enable),
        .bram_addr         (bram_addr),
        .buf_done          (buf_done),
        .fill_level        (fill_level)
    );

    dram_stream_packer #(
        .IN_W   (8),
        .OUT_W  (16),
        .ADDR_W (2),
        .DEPTH  (4)
    ) dut_sm (
        .clk               (clk),
        .rst               (rst),
        .clear             (1'b0),
        .in_data           (sm_in_data),
        .in_valid          (sm_in_valid),
        .in_ready          (sm_in_ready),
        .flush             (1'b0),
        .bram_data         (sm_bram_data),
        .bram_write_enable (sm_bram_we),
        .bram_addr         (sm_bram_addr),
        .buf_done          (sm_buf_done),
        .fill_level        (sm_fill_level)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst && bram_write_enable) begin
            wr_data_q.push_back(bram_data);
            wr_addr_q.push_back(bram_addr);
        end
        if (rst && sm_bram_we) begin
            sm_data_q.push_back(sm_bram_data);
            sm_addr_q.push_back(sm_bram_addr);
            sm_done_q.push_back(sm_buf_done);
        end
    end

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        in_data  = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_sm(input logic [7:0] b);
        sm_in_data  = b;
        sm_in_valid = 1'b1;
        @(posedge clk);
        #1;
        sm_in_valid = 1'b0;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        idle(3);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        wr_data_q.delete();
        wr_addr_q.delete();
    endtask

    logic [162:0]  exp_c;
    logic [162:0]  exp_r;
    logic [1303:0] stream;
    logic [7:0]    b;
    int            n;

    initial begin
        // bytes 1..20 fill the top 160 bits; 0x15[7:5]=000 completes the word
        exp_c = '0;
        for (int i = 1; i <= 20; i++) exp_c = {exp_c[154:0], 8'(i)};
        exp_c = {exp_c[159:0], 3'b000};
        exp_r = {5'b10101, 158'b0};

        // reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_data", 256'(bram_data), 256'(0));
        check("rst_we", 256'(bram_write_enable), 256'(0));
        check("rst_addr", 256'(bram_addr), 256'(0));
        check("rst_done", 256'(buf_done), 256'(0));
        check("rst_fill", 256'(fill_level), 256'(0));
        check("rst_ready", 256'(in_ready), 256'(1));
        rst = 1'b1;
        idle(1);

        // carry-over across a word boundary
        for (int i = 1; i <= 21; i++) send(8'(i));
        idle(2);
        check("co_nwr", 256'(wr_data_q.size()), 256'(1));
        if (wr_data_q.size() >= 1) begin
            check("co_addr", 256'(wr_addr_q[0]), 256'(0));
            check("co_data", 256'(wr_data_q[0]), 256'(exp_c));
        end
        check("co_fill", 256'(fill_level), 256'(5));
        do_flush();
        check("co_fl_nwr", 256'(wr_data_q.size()), 256'(2));
        if (wr_data_q.size() >= 2) begin
            check("co_fl_addr", 256'(wr_addr_q[1]), 256'(1));
            check("co_fl_data", 256'(wr_data_q[1]), 256'(exp_r));
        end
        check("co_fl_fill", 256'(fill_level), 256'(0));

        // flush of a partial word, then an empty flush
        do_clear();
        for (int i = 0; i < 5; i++) send(8'hFF);
        check("fp_fill", 256'(fill_level), 256'(40));
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("fp_ready_in_flush", 256'(in_ready), 256'(0));
        idle(3);
        check("fp_nwr", 256'(wr_data_q.size()), 256'(1));
        if (wr_data_q.size() >= 1) begin
            check("fp_addr", 256'(wr_addr_q[0]), 256'(0));
            check("fp_data", 256'(wr_data_q[0]), 256'({{40{1'b1}}, 123'b0}));
        end
        check("fp_fill0", 256'(fill_level), 256'(0));
        do_flush();
        check("fp2_nwr", 256'(wr_data_q.size()), 256'(1));
        check("fp2_addr", 256'(bram_addr), 256'(1));

        // flush coinciding with a word-completing beat: two writes
        do_clear();
        for (int i = 1; i <= 20; i++) send(8'(i));
        in_data  = 8'h15;
        in_valid = 1'b1;
        flush    = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        flush    = 1'b0;
        idle(3);
        check("fb_nwr", 256'(wr_data_q.size()), 256'(2));
        if (wr_data_q.size() >= 2) begin
            check("fb_addr0", 256'(wr_addr_q[0]), 256'(0));
            check("fb_data0", 256'(wr_data_q[0]), 256'(exp_c));
            check("fb_addr1", 256'(wr_addr_q[1]), 256'(1));
            check("fb_data1", 256'(wr_data_q[1]), 256'(exp_r));
        end
        check("fb_fill", 256'(fill_level), 256'(0));

        // clear discards a beat presented in the same cycle
        clear    = 1'b1;
        in_data  = 8'hFF;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        clear    = 1'b0;
        in_valid = 1'b0;
        wr_data_q.delete();
        wr_addr_q.delete();
        check("cl_fill", 256'(fill_level), 256'(0));
        check("cl_addr", 256'(bram_addr), 256'(0));
        send(8'h80);
        do_flush();
        check("cl_nwr", 256'(wr_data_q.size()), 256'(1));
        if (wr_data_q.size() >= 1)
            check("cl_data", 256'(wr_data_q[0]), 256'({8'h80, 155'b0}));

        // exact alignment: 163 bytes make exactly 8 words
        do_clear();
        stream = '0;
        for (int i = 0; i < 163; i++) begin
            b = 8'((i * 37 + 5) & 8'hFF);
            stream[1303 - 8*i -: 8] = b;
            send(b);
        end
        idle(2);
        check("al_nwr", 256'(wr_data_q.size()), 256'(8));
        n = (wr_data_q.size() < 8) ? wr_data_q.size() : 8;
        for (int k = 0; k < n; k++) begin
            check($sformatf("al_addr%0d", k), 256'(wr_addr_q[k]), 256'(k));
            check($sformatf("al_data%0d", k), 256'(wr_data_q[k]), 256'(stream[1303 - 163*k -: 163]));
        end
        check("al_fill", 256'(fill_level), 256'(0));

        // asynchronous reset mid-stream
        for (int i = 0; i < 10; i++) send(8'(8'h11 + i));
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check("ar_data", 256'(bram_data), 256'(0));
        check("ar_we", 256'(bram_write_enable), 256'(0));
        check("ar_addr", 256'(bram_addr), 256'(0));
        check("ar_fill", 256'(fill_level), 256'(0));
        check("ar_ready", 256'(in_ready), 256'(1));
        idle(1);
        rst = 1'b1;
        wr_data_q.delete();
        wr_addr_q.delete();
        sm_data_q.delete();
        sm_addr_q.delete();
        sm_done_q.delete();
        idle(1);
        send(8'hA5);
        do_flush();
        check("ar_nwr", 256'(wr_data_q.size()), 256'(1));
        if (wr_data_q.size() >= 1) begin
            check("ar_top", 256'(wr_data_q[0][162:155]), 256'(8'hA5));
            check("ar_waddr", 256'(wr_addr_q[0]), 256'(0));
        end

        // address wrap and buf_done on the DEPTH=4 instance
        for (int i = 0; i < 10; i++) send_sm(8'(8'h30 + i));
        idle(2);
        check("wr_nwr", 256'(sm_data_q.size()), 256'(5));
        n = (sm_data_q.size() < 5) ? sm_data_q.size() : 5;
        for (int k = 0; k < n; k++) begin
            check($sformatf("wr_addr%0d", k), 256'(sm_addr_q[k]), 256'(k % 4));
            check($sformatf("wr_done%0d", k), 256'(sm_done_q[k]), 256'(k == 3));
            check($sformatf("wr_data%0d", k), 256'(sm_data_q[k]),
                  256'({8'(8'h30 + 2*k), 8'(8'h31 + 2*k)}));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
